fifo_lvl: RTL and testbench
===========================

// Module: fifo_lvl
// PURPOSE
// - Parametrised synchronous FIFO; next generation of the UART RX/TX buffer, also for MIPS debug-unit streams.
// - Adds occupancy count, programmable almost-full/almost-empty flags and synchronous flush.
// - Correct simultaneous read/write at the full and empty boundaries.
// - Show-ahead read port (data valid while !empty); single clock domain.
// PARAMETERS
// - B         8   data word width, bits
// - W         4   address bits; DEPTH = 2**W entries
// - AF_LEVEL  14  almost_full asserted when count >= AF_LEVEL (1..DEPTH)
// - AE_LEVEL  2   almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
// PORTS
// - clk           in   1    clock, rising edge
// - reset         in   1    synchronous, active-high
// - flush         in   1    sync clear of contents; memory array untouched
// - wr            in   1    write request
// - w_data        in   B    write data
// - rd            in   1    read request; pops the word currently on r_data
// - r_data        out  B    head word; undefined while empty
// - empty         out  1    no words stored
// - full          out  1    DEPTH words stored
// - almost_empty  out  1    count <= AE_LEVEL
// - almost_full   out  1    count >= AF_LEVEL
// - count         out  W+1  words stored, 0..DEPTH
// - overflow      out  1    sticky: wr while full (macro-gated)
// - underflow     out  1    sticky: rd while empty (macro-gated)
// BEHAVIOUR
// - Reset:
//   - Pointers = 0, count = 0, empty = 1, full = 0, almost_empty = 1.
//   - almost_full = (AF_LEVEL == 0), i.e. 0 for legal settings.
//   - overflow = 0, underflow = 0.
// - All flags and count are registered. Decisions use registered state only:
//   - wr_acc = wr & ~full
//   - rd_acc = rd & ~empty
// - wr_acc: mem[w_ptr] <= w_data; w_ptr wraps modulo DEPTH.
// - rd_acc: r_ptr advances, wrapping modulo DEPTH.
// - Count update: wr_acc only +1; rd_acc only -1; both or neither: unchanged.
// - Flags are derived from count_next and registered:
//   - empty = (count_next == 0)
//   - full = (count_next == DEPTH)
//   - almost_* compare count_next against AF_LEVEL / AE_LEVEL.
// - Latency:
//   - Word written at edge N is on r_data with empty = 0 after edge N.
//   - Read-to-next-head: r_data shows the next word after the popping edge.
// - Boundaries:
//   - Empty, wr & rd: write only; rd ignored; count 0 -> 1.
//   - Full, wr & rd: read only; wr dropped; count DEPTH -> DEPTH-1.
//   - Full & wr: data dropped, no state change.
//   - Empty & rd: no state change; r_data don't-care.
// - flush:
//   - Same-cycle effect as reset on pointers, count and flags.
//   - Priority: reset > flush > wr/rd; wr/rd in the flush cycle are ignored.
//   - overflow/underflow are NOT cleared by flush; only reset clears them.
// - Reset or flush mid-stream discards all stored words; no partial state survives.
// CONFIGURATION
// - FIFO_ERR_FLAGS_EN defined:
//   - overflow <= 1 on any cycle with wr & full.
//   - underflow <= 1 on any cycle with rd & empty.
//   - Both hold until reset.
// - FIFO_ERR_FLAGS_EN undefined: overflow and underflow are tied 0; no sticky registers are inferred.
// TESTING
// - Fill: B=8, W=4; write 0x00..0x0F over 16 cycles.
//   - full = 1 after 16th edge, count = 16.
//   - almost_full rises at count = 14.
// - Drain: read 16 words -> r_data sequence 0x00..0x0F, then empty = 1, count = 0.
//   - almost_empty rises at count = 2.
// - Boundary r/w: pulse wr & rd together.
//   - When empty: count 0 -> 1, r_data = w_data.
//   - When full: count 16 -> 15; dropped word never appears.
// - Wrap: 40 interleaved writes/reads with count held at 3.
//   - Data order preserved across pointer wrap; flags stable.
// - Flush at count = 9 with wr = 1 in the same cycle.
//   - Next cycle: count = 0, empty = 1; flushed data never read back.
// - Errors, macro on: wr when full -> overflow = 1; rd when empty -> underflow = 1.
//   - Both persist through flush; cleared by reset.
//   - Macro off: both stay 0.

Source files
------------

// File: rtl/fifo_lvl.sv
// ---------------------------------------------------------------------------
// fifo_lvl
// Parametrised single-clock synchronous FIFO with a show-ahead read port,
// occupancy count, programmable almost-full / almost-empty flags and a
// synchronous flush. Used as the UART RX/TX buffer and for debug-unit streams.
//
// Parameters
//   B         data word width in bits
//   W         address bits; DEPTH = 2**W entries
//   AF_LEVEL  almost_full  when count >= AF_LEVEL
//   AE_LEVEL  almost_empty when count <= AE_LEVEL
//
// Ports
//   clk           in   1    clock, rising edge
//   reset         in   1    synchronous, active-high
//   flush         in   1    synchronous clear of pointers/count/flags
//   wr            in   1    write request
//   w_data        in   B    write data
//   rd            in   1    read request; pops the word shown on r_data
//   r_data        out  B    head word (show-ahead); undefined while empty
//   empty         out  1    no words stored
//   full          out  1    DEPTH words stored
//   almost_empty  out  1    count <= AE_LEVEL
//   almost_full   out  1    count >= AF_LEVEL
//   count         out  W+1  words stored, 0..DEPTH
//   overflow      out  1    sticky: wr seen while full
//   underflow     out  1    sticky: rd seen while empty
//
// Configuration
//   FIFO_ERR_FLAGS_EN  when defined, overflow/underflow are sticky error
//                      registers cleared only by reset; otherwise both
//                      outputs are tied low.
// ---------------------------------------------------------------------------
module fifo_lvl #(
   parameter int B        = 8,
   parameter int W        = 4,
   parameter int AF_LEVEL = 14,
   parameter int AE_LEVEL = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         wr,
   input  logic [B-1:0] w_data,
   input  logic         rd,
   output logic [B-1:0] r_data,
   output logic         empty,
   output logic         full,
   output logic         almost_empty,
   output logic         almost_full,
   output logic [W:0]   count,
   output logic         overflow,
   output logic         underflow
);

   localparam int         DEPTH   = 2**W;
   localparam logic [W:0] DEPTH_C = (W+1)'(DEPTH);

   logic [B-1:0] r_mem [DEPTH];
   logic [W-1:0] r_wptr;
   logic [W-1:0] r_rptr;
   logic [W:0]   r_count;
   logic         r_empty;
   logic         r_full;
   logic         r_ae;
   logic         r_af;

   logic         w_wr_acc;
   logic         w_rd_acc;
   logic         w_clr;
   logic [W:0]   w_count_next;

   // Acceptance looks only at registered flags, so a simultaneous wr/rd at
   // the empty boundary becomes a pure write and at the full boundary a
   // pure read.
   assign w_wr_acc = wr & ~r_full;
   assign w_rd_acc = rd & ~r_empty;
   assign w_clr    = reset | flush;

   always_comb begin
      w_count_next = r_count;
      if (w_clr)
         w_count_next = '0;
      else if (w_wr_acc && !w_rd_acc)
         w_count_next = r_count + 1'b1;
      else if (!w_wr_acc && w_rd_acc)
         w_count_next = r_count - 1'b1;
   end

   // Pointer and flag state; flags come from count_next so they line up
   // with count in the same cycle, and clear values fall out of count = 0.
   always_ff @(posedge clk) begin
      if (w_clr) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_wr_acc) r_wptr <= r_wptr + 1'b1;
         if (w_rd_acc) r_rptr <= r_rptr + 1'b1;
      end
      r_count <= w_count_next;
      r_empty <= (w_count_next == '0);
      r_full  <= (w_count_next == DEPTH_C);
      r_ae    <= (int'(w_count_next) <= AE_LEVEL);
      r_af    <= (int'(w_count_next) >= AF_LEVEL);
   end

   // Storage array carries no reset; stale contents are unreachable once
   // the pointers are cleared.
   always_ff @(posedge clk) begin
      if (!w_clr && w_wr_acc)
         r_mem[r_wptr] <= w_data;
   end

   assign r_data       = r_mem[r_rptr];
   assign empty        = r_empty;
   assign full         = r_full;
   assign almost_empty = r_ae;
   assign almost_full  = r_af;
   assign count        = r_count;

`ifdef FIFO_ERR_FLAGS_EN
   logic r_ovf;
   logic r_unf;

   // Sticky error flags survive flush; only reset clears them.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         if (wr && r_full)  r_ovf <= 1'b1;
         if (rd && r_empty) r_unf <= 1'b1;
      end
   end

   assign overflow  = r_ovf;
   assign underflow = r_unf;
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_lvl.sv
// ---------------------------------------------------------------------------
// tb_fifo_lvl
// Self-checking bench for fifo_lvl (B=8, W=4, AF_LEVEL=14, AE_LEVEL=2).
// A table of single-cycle vectors with hand-derived expected state is run
// first, followed by hand-written fill / drain / boundary / wrap / flush /
// error-flag sequences. Data is checked through a scoreboard queue: words
// are pushed when a write is accepted and popped and compared against r_data
// when a read is issued.
// ---------------------------------------------------------------------------
module tb_fifo_lvl;

   localparam int B     = 8;
   localparam int W     = 4;
   localparam int DEPTH = 16;
   localparam int AFL   = 14;
   localparam int AEL   = 2;

   logic         clk;
   logic         reset;
   logic         flush;
   logic         wr;
   logic [B-1:0] w_data;
   logic         rd;
   logic [B-1:0] r_data;
   logic         empty;
   logic         full;
   logic         almost_empty;
   logic         almost_full;
   logic [W:0]   count;
   logic         overflow;
   logic         underflow;

   fifo_lvl #(.B(B), .W(W), .AF_LEVEL(AFL), .AE_LEVEL(AEL)) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .wr           (wr),
      .w_data       (w_data),
      .rd           (rd),
      .r_data       (r_data),
      .empty        (empty),
      .full         (full),
      .almost_empty (almost_empty),
      .almost_full  (almost_full),
      .count        (count),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       wr;
      logic       rd;
      logic       fl;
      logic [7:0] d;
      int         cnt;
      logic       e;
      logic       f;
      logic       ae;
      logic       af;
   } vec_t;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] sb[$];
   logic       exp_ovf  = 1'b0;
   logic       exp_unf  = 1'b0;
   vec_t       tbl[9];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                    name, act, act, exp, exp, $time);
   endtask

   task automatic check_state();
      int c;
      c = sb.size();
      chk("count",        int'(count),        c);
      chk("empty",        int'(empty),        int'(c == 0));
      chk("full",         int'(full),         int'(c == DEPTH));
      chk("almost_empty", int'(almost_empty), int'(c <= AEL));
      chk("almost_full",  int'(almost_full),  int'(c >= AFL));
      chk("overflow",     int'(overflow),     int'(exp_ovf));
      chk("underflow",    int'(underflow),    int'(exp_unf));
   endtask

   // One clock cycle of stimulus. Inputs are applied 1 time unit after the
   // previous rising edge; r_data is compared before the popping edge and
   // all registered state is compared 1 unit after it.
   task automatic cyc(input logic iw, input logic ir, input logic ifl,
                      input logic [7:0] id);
      int         c0;
      bit         wacc;
      bit         racc;
      logic [7:0] hd;
      c0   = sb.size();
      wacc = iw && !ifl && (c0 < DEPTH);
      racc = ir && !ifl && (c0 > 0);
      wr = iw; rd = ir; flush = ifl; w_data = id;
      #1;
      if (racc) begin
         hd = sb.pop_front();
         chk("r_data", int'(r_data), int'(hd));
      end
`ifdef FIFO_ERR_FLAGS_EN
      if (iw && c0 == DEPTH) exp_ovf = 1'b1;
      if (ir && c0 == 0)     exp_unf = 1'b1;
`endif
      if (ifl) sb.delete();
      else if (wacc) sb.push_back(id);
      @(posedge clk);
      #1;
      wr = 1'b0; rd = 1'b0; flush = 1'b0; w_data = '0;
      check_state();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb.delete();
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
      check_state();
   endtask

   initial begin
      //            wr    rd    fl    data   cnt e     f     ae    af
      tbl[0] = '{1'b1, 1'b0, 1'b0, 8'hA0, 1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 8'hA1, 1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 8'hA2, 2, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 8'hA3, 3, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{1'b0, 1'b1, 1'b0, 8'h00, 2, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{1'b1, 1'b1, 1'b1, 8'hA4, 0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[6] = '{1'b1, 1'b1, 1'b0, 8'hA5, 1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[7] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0};
      tbl[8] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0};

      reset = 1'b1; flush = 1'b0; wr = 1'b0; rd = 1'b0; w_data = '0;

      // Reset state
      do_reset();

      // Table-driven single-cycle vectors
      for (int i = 0; i < 9; i++) begin
         cyc(tbl[i].wr, tbl[i].rd, tbl[i].fl, tbl[i].d);
         chk("tbl_count", int'(count),        tbl[i].cnt);
         chk("tbl_empty", int'(empty),        int'(tbl[i].e));
         chk("tbl_full",  int'(full),         int'(tbl[i].f));
         chk("tbl_ae",    int'(almost_empty), int'(tbl[i].ae));
         chk("tbl_af",    int'(almost_full),  int'(tbl[i].af));
      end

      // Fill 0x00..0x0F
      do_reset();
      for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, 1'b0, 8'(i));
      chk("fill_full",  int'(full),  1);
      chk("fill_count", int'(count), 16);

      // Write while full: dropped, overflow (when enabled)
      cyc(1'b1, 1'b0, 1'b0, 8'hEE);
      // Full with wr & rd: read only, 16 -> 15, 0xDD dropped
      cyc(1'b1, 1'b1, 1'b0, 8'hDD);
      chk("full_wrrd_count", int'(count), 15);

      // Drain remaining 0x01..0x0F
      for (int i = 0; i < DEPTH - 1; i++) cyc(1'b0, 1'b1, 1'b0, 8'h00);
      chk("drain_empty", int'(empty), 1);

      // Read while empty: no state change, underflow (when enabled)
      cyc(1'b0, 1'b1, 1'b0, 8'h00);

      // Empty with wr & rd: write only, show-ahead data
      cyc(1'b1, 1'b1, 1'b0, 8'h5A);
      chk("empty_wrrd_count", int'(count), 1);
      chk("show_ahead", int'(r_data), 8'h5A);
      cyc(1'b0, 1'b1, 1'b0, 8'h00);

      // Wrap: hold count at 3 over 40 simultaneous writes/reads
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'h80 + i));
      for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, 1'b0, 8'(8'h90 + i));
      chk("wrap_count", int'(count), 3);

      // Flush at count 9 with a concurrent write
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
      chk("preflush_count", int'(count), 9);
      cyc(1'b1, 1'b0, 1'b1, 8'h77);
      chk("flush_count", int'(count), 0);
      chk("flush_empty", int'(empty), 1);
      cyc(1'b1, 1'b0, 1'b0, 8'h33);
      chk("post_flush_head", int'(r_data), 8'h33);
      cyc(1'b0, 1'b1, 1'b0, 8'h00);

      // Sticky flags survive flush (checked in check_state), cleared by reset
      do_reset();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
